// File: rtl/datamem_banked.sv
// Byte-addressed, word-organised data memory with byte strobes, programmable wait states and a ready pulse.
// Optional alignment checking is enabled with `define DMEM_ALIGN_CHECK_EN.
module datamem_banked #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     writeData,
   input  logic [DATA_W/8-1:0]   byteEn,
   output logic [DATA_W-1:0]     readdata,
   output logic                  ready,
   output logic                  busy
`ifdef DMEM_ALIGN_CHECK_EN
   ,
   output logic                  misaligned
`endif
);

   localparam int unsigned LANES = DATA_W / 8;
   localparam int unsigned OFFS  = $clog2(LANES);
   localparam int unsigned IDX   = $clog2(DEPTH);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               op_rd;
   logic               op_wr;
   logic [IDX-1:0]     idx_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [LANES-1:0]   be_q;
   logic               bad_q;
   logic               bad_c;

   logic [DATA_W-1:0]  mem [DEPTH] = '{default: '0};

   // Upper address bits alias onto the array; low offset bits only matter for alignment.
   logic unused_addr;
   assign unused_addr = ^address;

`ifdef DMEM_ALIGN_CHECK_EN
   assign bad_c = (address & ADDR_W'((64'd1 << OFFS) - 64'd1)) != '0;
`else
   assign bad_c = 1'b0;
`endif

   // Access sequencer: accept, optional wait, then perform the access with a ready pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         readdata <= '0;
         ready    <= 1'b0;
         busy     <= 1'b0;
         op_rd    <= 1'b0;
         op_wr    <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         bad_q    <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
         misaligned <= 1'b0;
`endif
      end else begin
         ready <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
         misaligned <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (memRead || memWrite) begin
                  op_rd   <= memRead;
                  op_wr   <= memWrite;
                  idx_q   <= address[OFFS +: IDX];
                  wdata_q <= writeData;
                  be_q    <= byteEn;
                  bad_q   <= bad_c;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               if (cnt == WAIT_LAST) state <= S_RESP;
               else                  cnt   <= cnt + CNT_W'(1);
            end
            S_RESP: begin
               ready <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
               if (op_rd) readdata <= bad_q ? '0 : mem[idx_q];
`ifdef DMEM_ALIGN_CHECK_EN
               misaligned <= bad_q;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Write commit; non-blocking update keeps read-before-write ordering on combined requests.
   always_ff @(posedge clk) begin
      if (!rst && state == S_RESP && op_wr && !bad_q) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_datamem_banked.sv
// Self-checking bench for datamem_banked: two instances (0 and 3 wait states) against an array reference model.
module tb_datamem_banked;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned DEPTH = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic            rd_s   [2];
   logic            wr_s   [2];
   logic [AW-1:0]   addr_s [2];
   logic [DW-1:0]   wd_s   [2];
   logic [3:0]      be_s   [2];
   logic [DW-1:0]   rdata_s[2];
   logic            rdy_s  [2];
   logic            busy_s [2];
`ifdef DMEM_ALIGN_CHECK_EN
   logic            mis_s  [2];
`endif

   int cmp  = 0;
   int errs = 0;

   logic [DW-1:0] model [2][DEPTH];
   logic [DW-1:0] exp_rd[2];

   always #5 clk = ~clk;

   datamem_banked #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .memRead(rd_s[0]), .memWrite(wr_s[0]), .address(addr_s[0]),
      .writeData(wd_s[0]), .byteEn(be_s[0]), .readdata(rdata_s[0]), .ready(rdy_s[0]),
      .busy(busy_s[0])
`ifdef DMEM_ALIGN_CHECK_EN
      , .misaligned(mis_s[0])
`endif
   );

   datamem_banked #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .memRead(rd_s[1]), .memWrite(wr_s[1]), .address(addr_s[1]),
      .writeData(wd_s[1]), .byteEn(be_s[1]), .readdata(rdata_s[1]), .ready(rdy_s[1]),
      .busy(busy_s[1])
`ifdef DMEM_ALIGN_CHECK_EN
      , .misaligned(mis_s[1])
`endif
   );

   function automatic int wcyc(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   function automatic bit is_misal(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
      return (a % 4) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // One complete access on instance d, with latency, busy, data and pulse-width checks.
   task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wdt, input logic [3:0] b, input string tag);
      int lat, bcnt;
      bit seen, bad, busy_at_rdy;
      logic [31:0] word;
      bad = is_misal(a);
      @(negedge clk);
      rd_s[d] = r; wr_s[d] = w; addr_s[d] = a; wd_s[d] = wdt; be_s[d] = b;
      @(posedge clk); #1;
      lat = 0; bcnt = 0; seen = 0; busy_at_rdy = 0;
      if (busy_s[d]) bcnt++;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(posedge clk); #1;
         lat++;
         if (rdy_s[d]) begin
            seen = 1;
            busy_at_rdy = busy_s[d];
         end else if (busy_s[d]) bcnt++;
      end
      rd_s[d] = 0; wr_s[d] = 0;
      if (r) exp_rd[d] = bad ? '0 : model[d][widx(a)];
      if (w && !bad) begin
         word = model[d][widx(a)];
         for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = wdt[8*i +: 8];
         model[d][widx(a)] = word;
      end
      cmp++;
      if (!seen || lat != wcyc(d) + 1) begin
         errs++;
         $display("FAIL %s latency dut%0d: got %0d (seen=%0d) want %0d", tag, d, lat, seen, wcyc(d) + 1);
      end
      cmp++;
      if (bcnt != wcyc(d) + 1 || busy_at_rdy) begin
         errs++;
         $display("FAIL %s busy dut%0d: got %0d cycles (busy_at_ready=%0d) want %0d", tag, d, bcnt, busy_at_rdy, wcyc(d) + 1);
      end
      cmp++;
      if (rdata_s[d] !== exp_rd[d]) begin
         errs++;
         $display("FAIL %s readdata dut%0d addr=%h: got %h want %h", tag, d, a, rdata_s[d], exp_rd[d]);
      end
`ifdef DMEM_ALIGN_CHECK_EN
      cmp++;
      if (mis_s[d] !== bad) begin
         errs++;
         $display("FAIL %s misaligned dut%0d addr=%h: got %b want %b", tag, d, a, mis_s[d], bad);
      end
`endif
      @(posedge clk); #1;
      cmp++;
      if (rdy_s[d] !== 1'b0) begin
         errs++;
         $display("FAIL %s ready_pulse dut%0d: got %b want 0", tag, d, rdy_s[d]);
      end
`ifdef DMEM_ALIGN_CHECK_EN
      cmp++;
      if (mis_s[d] !== 1'b0) begin
         errs++;
         $display("FAIL %s misaligned_clear dut%0d: got %b want 0", tag, d, mis_s[d]);
      end
`endif
   endtask

   task automatic test_reset();
      for (int e = 0; e < 2; e++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            cmp++;
            if (rdy_s[d] !== 1'b0 || busy_s[d] !== 1'b0 || rdata_s[d] !== '0) begin
               errs++;
               $display("FAIL reset dut%0d: got ready=%b busy=%b readdata=%h want 0/0/0", d, rdy_s[d], busy_s[d], rdata_s[d]);
            end
         end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin rd_s[d] = 0; exp_rd[d] = '0; end
      rst = 0;
      for (int e = 0; e < 5; e++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            cmp++;
            if (rdy_s[d] !== 1'b0 || busy_s[d] !== 1'b0) begin
               errs++;
               $display("FAIL reset_release dut%0d: got ready=%b busy=%b want 0/0", d, rdy_s[d], busy_s[d]);
            end
         end
      end
   endtask

   task automatic test_basic();
      for (int d = 0; d < 2; d++) begin
         access(d, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, "basic_wr");
         access(d, 1, 0, 32'h10, 32'h0, 4'h0, "basic_rd");
         cmp++;
         if (rdata_s[d] !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL basic_const dut%0d: got %h want deadbeef", d, rdata_s[d]);
         end
      end
   endtask

   task automatic test_byte_lanes();
      for (int d = 0; d < 2; d++) begin
         access(d, 0, 1, 32'h10, 32'h11223344, 4'b0101, "lanes_wr");
         access(d, 1, 0, 32'h10, 32'h0, 4'h0, "lanes_rd");
         cmp++;
         if (rdata_s[d] !== 32'hDE22BE44) begin
            errs++;
            $display("FAIL lanes_const dut%0d: got %h want de22be44", d, rdata_s[d]);
         end
         access(d, 0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, "lanes_none");
         access(d, 1, 0, 32'h10, 32'h0, 4'h0, "lanes_none_rd");
      end
   endtask

   task automatic test_alias_rmw();
      for (int d = 0; d < 2; d++) begin
         access(d, 0, 1, 32'h1004, 32'hA5A5A5A5, 4'hF, "alias_wr");
         access(d, 1, 0, 32'h0004, 32'h0, 4'h0, "alias_rd");
         access(d, 1, 1, 32'h0004, 32'h0F0F1234, 4'hF, "rbw");
         cmp++;
         if (rdata_s[d] !== 32'hA5A5A5A5) begin
            errs++;
            $display("FAIL rbw_old dut%0d: got %h want a5a5a5a5", d, rdata_s[d]);
         end
         access(d, 0, 1, 32'h0010, 32'h77777777, 4'hF, "wr_no_rd_change");
         access(d, 1, 0, 32'hFFFF_F004, 32'h0, 4'h0, "rbw_new");
      end
   endtask

   task automatic test_back_to_back();
      for (int d = 0; d < 2; d++) begin
         int gap;
         bit s1, s2;
         @(negedge clk);
         rd_s[d] = 1; wr_s[d] = 0; addr_s[d] = 32'h10; be_s[d] = 4'h0;
         s1 = 0; s2 = 0; gap = 0;
         for (int n = 0; n < 40 && !s1; n++) begin
            @(posedge clk); #1;
            if (rdy_s[d]) s1 = 1;
         end
         for (int n = 0; n < 40 && !s2; n++) begin
            @(posedge clk); #1;
            gap++;
            if (rdy_s[d]) s2 = 1;
         end
         rd_s[d] = 0;
         exp_rd[d] = model[d][4];
         cmp++;
         if (!s1 || !s2 || gap != wcyc(d) + 2) begin
            errs++;
            $display("FAIL b2b_gap dut%0d: got %0d (seen=%0d/%0d) want %0d", d, gap, s1, s2, wcyc(d) + 2);
         end
         cmp++;
         if (rdata_s[d] !== exp_rd[d]) begin
            errs++;
            $display("FAIL b2b_data dut%0d: got %h want %h", d, rdata_s[d], exp_rd[d]);
         end
         repeat (2) @(posedge clk);
      end
   endtask

   task automatic test_reset_abort();
      for (int d = 0; d < 2; d++) access(d, 0, 1, 32'h20, 32'hCAFE0000, 4'hF, "abort_prior");
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         wr_s[d] = 1; rd_s[d] = 0; addr_s[d] = 32'h20; wd_s[d] = 32'h1; be_s[d] = 4'hF;
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      for (int d = 0; d < 2; d++) wr_s[d] = 0;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         exp_rd[d] = '0;
         cmp++;
         if (rdy_s[d] !== 1'b0 || busy_s[d] !== 1'b0 || rdata_s[d] !== '0) begin
            errs++;
            $display("FAIL abort_reset dut%0d: got ready=%b busy=%b readdata=%h want 0/0/0", d, rdy_s[d], busy_s[d], rdata_s[d]);
         end
      end
      @(negedge clk);
      rst = 0;
      repeat (6) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            cmp++;
            if (rdy_s[d] !== 1'b0) begin
               errs++;
               $display("FAIL abort_ghost dut%0d: got ready=%b want 0", d, rdy_s[d]);
            end
         end
      end
      for (int d = 0; d < 2; d++) access(d, 1, 0, 32'h20, 32'h0, 4'h0, "abort_rd");
   endtask

   task automatic test_misaligned();
      for (int d = 0; d < 2; d++) begin
         access(d, 0, 1, 32'h22, 32'h5555AAAA, 4'hF, "mis_wr");
         access(d, 1, 0, 32'h20, 32'h0, 4'h0, "mis_chk");
         access(d, 1, 0, 32'h23, 32'h0, 4'h0, "mis_rd");
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++) begin
         int d, op;
         logic [31:0] a;
         d  = k % 2;
         op = int'($urandom_range(0, 2));
         a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
         access(d, op != 1, op != 0, a, $urandom, 4'($urandom), "random");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < int'(DEPTH); i++) model[d][i] = '0;
         rd_s[d] = 1; wr_s[d] = 0; addr_s[d] = '0; wd_s[d] = '0; be_s[d] = '0;
         exp_rd[d] = '0;
      end
      rst = 1;
      test_reset();
      test_basic();
      test_byte_lanes();
      test_alias_rmw();
      test_back_to_back();
      test_reset_abort();
      test_misaligned();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule
